// File: rtl/mib_move_queue.sv
// ----------------------------------------------------------------------------
// mib_move_queue
//
// Circular-buffer FIFO of move instructions ({src, dest}) sitting between the
// control unit and the message-interconnect-bus move FSM. The head entry is
// presented combinationally and held stable until the FSM acknowledges it, so
// a partially completed transfer always sees the same ids.
//
// Ports:
//   clock, reset_n        : clock and asynchronous active-low reset
//   in_valid / in_ready   : control-unit push handshake
//   in_src, in_dest       : ids of the offered move
//   flush                 : synchronous clear of all queued moves
//   cu_valid / cu_ack     : head-move handshake towards the move FSM
//   cu_src, cu_dest       : ids of the head move (valid only with cu_valid)
//   count                 : number of occupied entries
// ----------------------------------------------------------------------------
module mib_move_queue #(
  parameter int DEPTH      = 4,
  parameter int SRC_WIDTH  = 4,
  parameter int DEST_WIDTH = 4
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [SRC_WIDTH-1:0]         in_src,
  input  logic [DEST_WIDTH-1:0]        in_dest,
  input  logic                         flush,
  output logic                         cu_valid,
  input  logic                         cu_ack,
  output logic [SRC_WIDTH-1:0]         cu_src,
  output logic [DEST_WIDTH-1:0]        cu_dest,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH+1);
  localparam int ENTRY_W = SRC_WIDTH + DEST_WIDTH;

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q,  count_d;

  logic push;
  logic pop;

  // in_ready looks only at registered occupancy and flush: a full queue
  // refuses a push even when the head is being acknowledged in the same cycle,
  // which keeps cu_ack out of the in_ready path and protects the head entry.
  assign in_ready = (count_q != FULL_COUNT) && !flush;
  assign cu_valid = (count_q != '0);
  assign count    = count_q;

  assign push = in_valid && in_ready;
  // A pop during flush is discarded along with everything else.
  assign pop  = cu_valid && cu_ack && !flush;

  assign {cu_src, cu_dest} = mem_q[rd_ptr_q];

  // Next-state for pointers and occupancy.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state: pointers and occupancy.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; entries are only ever
  // read after being written, and leaving the reset off lets it map to RAM.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= {in_src, in_dest};
  end

endmodule

// File: doc/mib_move_queue.md
# mib_move_queue

Buffers move instructions (source id, destination id) issued by the control unit and presents them one at a time to the message-interconnect-bus move FSM. The FSM consumes them through the `cu_valid`/`cu_ack` handshake. The queue sits directly upstream of the FSM. It decouples instruction issue from bus completion and holds the head message stable while the FSM is partway through a transfer, for example when the destination has acknowledged but the source has not.

## Interface

Parameters:

- `DEPTH`, default 4: number of entries. Must be a power of two and at least 2.
- `SRC_WIDTH`, default 4: width of the source endpoint id.
- `DEST_WIDTH`, default 4: width of the destination endpoint id.

Ports:

- `clock`, input, 1: the only clock. All state updates on its rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: the control unit offers a move instruction.
- `in_ready`, output, 1: the queue accepts the instruction this cycle.
- `in_src`, input, SRC_WIDTH: source id of the offered move.
- `in_dest`, input, DEST_WIDTH: destination id of the offered move.
- `flush`, input, 1: synchronous clear of all queued moves.
- `cu_valid`, output, 1: a head move is presented to the FSM.
- `cu_ack`, input, 1: the FSM has completed the head move.
- `cu_src`, output, SRC_WIDTH: source id of the head move.
- `cu_dest`, output, DEST_WIDTH: destination id of the head move.
- `count`, output, $clog2(DEPTH+1): number of occupied entries.

## Operation

- Storage is a circular buffer of DEPTH entries, each `{src, dest}`.
- Pointers:
  - Write pointer and read pointer are each $clog2(DEPTH) bits and wrap modulo DEPTH.
  - Occupancy is tracked by the `count` register.
- Push:
  - Condition: `in_valid && in_ready`.
  - Writes the entry at the write pointer, then increments the write pointer.
- Pop:
  - Condition: `cu_valid && cu_ack`.
  - Increments the read pointer.
  - `cu_ack` while `cu_valid` is 0 is ignored.
- `in_ready = (count != DEPTH) && !flush`.
  - A push into a full queue is never accepted, even if a pop occurs in the same cycle. This keeps `in_ready` free of a combinational dependency on `cu_ack`.
- Head outputs:
  - `cu_valid = (count != 0)`.
  - `cu_src`/`cu_dest` are read combinationally from the entry at the read pointer.
- Stability: while `cu_valid && !cu_ack`, `cu_src` and `cu_dest` hold unchanged. A push never overwrites the head entry, because a full queue rejects pushes.
- Simultaneous push and pop:
  - With `0 < count < DEPTH`: both happen and `count` is unchanged.
  - With `count == 0`: only the push happens, since `cu_valid` is 0.
- Flush:
  - Next cycle, the read pointer, write pointer and `count` are all 0.
  - A push or pop in the flush cycle is discarded.
  - The caller flushes only while the downstream FSM is idle. A flush during a partially acknowledged move is a usage error and is not detected.
- `count` update: +1 on a push without a pop, −1 on a pop without a push, otherwise unchanged.
  - Overflow above DEPTH is impossible by construction.
  - Underflow below 0 is impossible by construction.

## Timing

- Reset (asynchronous assertion, synchronous deassertion by the system):
  - Pointers = 0, `count` = 0.
  - `cu_valid` = 0, `in_ready` = 1.
  - `cu_src`/`cu_dest` are don't-care; the bench must not check them while `cu_valid` is 0.
- Storage array contents are not reset.
- Latency:
  - A push accepted in cycle N into an empty queue raises `cu_valid` in cycle N+1.
  - There is no same-cycle bypass.
- Pop:
  - A pop in cycle N presents the next entry in cycle N+1.
  - If the popped entry was the last one, `cu_valid` drops in cycle N+1.
- Throughput: one push and one pop per cycle sustained while `0 < count < DEPTH`.
- Full queue: `in_ready` is 0 in every cycle where `count == DEPTH`, and returns to 1 in the cycle after the first pop.
- Reset mid-operation: all queued moves are lost immediately. `cu_valid` drops asynchronously with `reset_n` assertion.
- `in_ready` depends only on registered state and `flush`. `cu_valid` depends only on registered state.

## Test plan

- Single move, DEPTH=4:
  - Push {src=3, dest=5} in cycle 1.
  - Required: `cu_valid`=1 with `cu_src`=3, `cu_dest`=5 in cycle 2.
  - Hold `cu_ack`=0 for 3 cycles: outputs stay stable.
  - Ack in cycle 5: `cu_valid`=0 and `count`=0 in cycle 6.
- Fill and order:
  - Push 4 moves {1,2}, {3,4}, {5,6}, {7,8} back to back: `count`=4 and `in_ready`=0.
  - A fifth `in_valid` is not accepted.
  - Ack every cycle: heads appear in push order. After the first ack, `in_ready`=1 in the next cycle.
- Wrap-around:
  - Run 10 push/pop pairs through a queue holding 2 entries.
  - Required: pointers wrap past 3, FIFO order is preserved, and `count` stays at 2 throughout.
- Simultaneous push+pop:
  - With `count`=2, push and ack in the same cycle: `count` stays 2 and the new head is the second entry.
  - With `count`=0, push and ack in the same cycle: `count`=1 afterwards.
- Flush:
  - With `count`=3, assert `flush` together with `in_valid`=1: `in_ready`=0 in that cycle.
  - Next cycle: `count`=0, `cu_valid`=0, and the new move was not stored.
- Async reset:
  - With `count`=2, drop `reset_n` mid-cycle: `cu_valid`=0 and `count`=0 before the next clock edge.
  - After release, the first push reappears after 1 cycle as normal.
